// File: rtl/sd_cmd_sequencer.sv
// Host-side SD command sequencer: CMD0/CMD7 bring-up, then CMD17 reads
// issued as byte-wide register writes into sdc_controller.
module sd_cmd_sequencer #(
  parameter logic [15:0] RCA              = 16'h0013,
  parameter int unsigned STARTUP_WAIT     = 25,
  parameter int unsigned CMD0_WAIT        = 250,
  parameter int unsigned CMD7_WAIT        = 500,
  parameter int unsigned READ_WAIT        = 20000,
  parameter logic [7:0]  R1_DATA_SETTINGS = 8'h5D
) (
  input  logic        clk,
  input  logic        rstn_async,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_block,
  output logic        rd_done,
  output logic        init_done,
  output logic        busy,
  output logic [6:0]  reg_addr,
  output logic [7:0]  reg_wdata,
  output logic        reg_we
);

  localparam logic [31:0] START_N =
    (STARTUP_WAIT == 0) ? 32'd1 : 32'(STARTUP_WAIT);
  localparam logic [31:0] CMD0_N =
    (CMD0_WAIT == 0) ? 32'd1 : 32'(CMD0_WAIT);
  localparam logic [31:0] CMD7_N =
    (CMD7_WAIT == 0) ? 32'd1 : 32'(CMD7_WAIT);
  localparam logic [31:0] READ_N =
    (READ_WAIT == 0) ? 32'd1 : 32'(READ_WAIT);

  typedef enum logic [2:0] {
    START_WAIT,
    CMD0_WR,
    CMD0_WAIT_S,
    CMD7_WR,
    CMD7_WAIT_S,
    IDLE,
    RD_WR,
    RD_WAIT
  } state_t;

  // {addr, data} of write number idx within a write-sequence state
  function automatic logic [14:0] wr_item(
    input state_t      st,
    input logic [2:0]  idx,
    input logic [31:0] blk
  );
    logic [14:0] v;
    v = '0;
    case (st)
      CMD0_WR: begin
        case (idx)
          3'd0:    v = {7'd5, 8'd0};
          default: v = {7'd0, 8'd0};
        endcase
      end
      CMD7_WR: begin
        case (idx)
          3'd0:    v = {7'd5, 8'd7};
          3'd1:    v = {7'd4, 8'd0};
          3'd2:    v = {7'd3, RCA[15:8]};
          3'd3:    v = {7'd2, RCA[7:0]};
          3'd4:    v = {7'd1, 8'd0};
          default: v = {7'd0, 8'd0};
        endcase
      end
      RD_WR: begin
        case (idx)
          3'd0:    v = {7'h48, 8'd0};
          3'd1:    v = {7'd5, 8'd17};
          3'd2:    v = {7'd4, R1_DATA_SETTINGS};
          3'd3:    v = {7'd3, blk[31:24]};
          3'd4:    v = {7'd2, blk[23:16]};
          3'd5:    v = {7'd1, blk[15:8]};
          default: v = {7'd0, blk[7:0]};
        endcase
      end
      default: v = '0;
    endcase
    return v;
  endfunction

  state_t      r_state;
  logic [31:0] r_cnt;
  logic [2:0]  r_idx;
  logic [31:0] r_blk;
  logic [6:0]  r_addr;
  logic [7:0]  r_wdata;
  logic        r_we;
  logic        r_ready;
  logic        r_rd_done;
  logic        r_init;
  logic        r_busy;

  logic [2:0]  w_last;
  state_t      w_wait_st;
  logic [31:0] w_wait_n;
  logic [14:0] w_item_nxt;
  logic [31:0] w_cnt_dec;

  always_comb begin
    w_last    = 3'd0;
    w_wait_st = IDLE;
    w_wait_n  = 32'd1;
    case (r_state)
      CMD0_WR: begin
        w_last    = 3'd1;
        w_wait_st = CMD0_WAIT_S;
        w_wait_n  = CMD0_N;
      end
      CMD7_WR: begin
        w_last    = 3'd5;
        w_wait_st = CMD7_WAIT_S;
        w_wait_n  = CMD7_N;
      end
      RD_WR: begin
        w_last    = 3'd6;
        w_wait_st = RD_WAIT;
        w_wait_n  = READ_N;
      end
      default: ;
    endcase
  end

  assign w_item_nxt = wr_item(r_state, r_idx + 3'd1, r_blk);
  assign w_cnt_dec  = r_cnt - 32'd1;

  always_ff @(posedge clk or negedge rstn_async) begin
    if (!rstn_async) begin
      r_state   <= START_WAIT;
      r_cnt     <= START_N;
      r_idx     <= 3'd0;
      r_blk     <= 32'd0;
      r_addr    <= 7'd0;
      r_wdata   <= 8'd0;
      r_we      <= 1'b0;
      r_ready   <= 1'b0;
      r_rd_done <= 1'b0;
      r_init    <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      r_rd_done <= 1'b0;
      case (r_state)
        START_WAIT: begin
          if (r_cnt == 32'd0) begin
            r_state            <= CMD0_WR;
            r_idx              <= 3'd0;
            {r_addr, r_wdata}  <= wr_item(CMD0_WR, 3'd0, r_blk);
          end else begin
            r_cnt <= w_cnt_dec;
          end
        end
        CMD0_WR, CMD7_WR, RD_WR: begin
          if (!r_we) begin
            r_we <= 1'b1;
          end else begin
            r_we <= 1'b0;
            if (r_idx == w_last) begin
              r_state <= w_wait_st;
              r_cnt   <= w_wait_n;
              r_addr  <= 7'd0;
              r_wdata <= 8'd0;
              // a one-cycle read wait ends on its first cycle
              if (r_state == RD_WR && w_wait_n == 32'd1)
                r_rd_done <= 1'b1;
            end else begin
              r_idx             <= r_idx + 3'd1;
              {r_addr, r_wdata} <= w_item_nxt;
            end
          end
        end
        CMD0_WAIT_S: begin
          if (r_cnt == 32'd1) begin
            r_state           <= CMD7_WR;
            r_idx             <= 3'd0;
            {r_addr, r_wdata} <= wr_item(CMD7_WR, 3'd0, r_blk);
          end else begin
            r_cnt <= w_cnt_dec;
          end
        end
        CMD7_WAIT_S: begin
          if (r_cnt == 32'd1) begin
            r_state <= IDLE;
            r_init  <= 1'b1;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= w_cnt_dec;
          end
        end
        IDLE: begin
          if (req_valid) begin
            r_blk             <= req_block;
            r_state           <= RD_WR;
            r_idx             <= 3'd0;
            {r_addr, r_wdata} <= wr_item(RD_WR, 3'd0, req_block);
            r_ready           <= 1'b0;
            r_busy            <= 1'b1;
          end
        end
        RD_WAIT: begin
          if (r_cnt == 32'd1) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= w_cnt_dec;
            // pulse lands on the last wait cycle
            if (r_cnt == 32'd2)
              r_rd_done <= 1'b1;
          end
        end
        default: r_state <= START_WAIT;
      endcase
    end
  end

  assign reg_addr  = r_addr;
  assign reg_wdata = r_wdata;
  assign reg_we    = r_we;
  assign req_ready = r_ready;
  assign rd_done   = r_rd_done;
  assign init_done = r_init;
  assign busy      = r_busy;

endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// Directed bench for sd_cmd_sequencer: default-parameter bring-up on one
// instance, short-wait reads and mid-read reset on a second.
module tb_sd_cmd_sequencer;

  typedef struct packed {
    int         cyc;
    logic [6:0] a;
    logic [7:0] d;
  } wr_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // default-parameter instance
  logic        d_rstn, d_valid, d_ready, d_done, d_init, d_busy, d_we;
  logic [31:0] d_block;
  logic [6:0]  d_addr;
  logic [7:0]  d_wdata;

  sd_cmd_sequencer u_def (
    .clk(clk), .rstn_async(d_rstn),
    .req_valid(d_valid), .req_ready(d_ready), .req_block(d_block),
    .rd_done(d_done), .init_done(d_init), .busy(d_busy),
    .reg_addr(d_addr), .reg_wdata(d_wdata), .reg_we(d_we)
  );

  // short-wait instance
  logic        o_rstn, o_valid, o_ready, o_done, o_init, o_busy, o_we;
  logic [31:0] o_block;
  logic [6:0]  o_addr;
  logic [7:0]  o_wdata;

  sd_cmd_sequencer #(
    .CMD0_WAIT(4), .CMD7_WAIT(4), .READ_WAIT(10)
  ) u_ovr (
    .clk(clk), .rstn_async(o_rstn),
    .req_valid(o_valid), .req_ready(o_ready), .req_block(o_block),
    .rd_done(o_done), .init_done(o_init), .busy(o_busy),
    .reg_addr(o_addr), .reg_wdata(o_wdata), .reg_we(o_we)
  );

  int cyc_d = -1;
  int cyc_o = -1;
  always @(posedge clk or negedge d_rstn)
    if (!d_rstn) cyc_d <= -1; else cyc_d <= cyc_d + 1;
  always @(posedge clk or negedge o_rstn)
    if (!o_rstn) cyc_o <= -1; else cyc_o <= cyc_o + 1;

  wr_t q_d[$];
  wr_t q_o[$];
  int  q_d_init[$];
  int  q_d_rdy[$];
  int  q_o_init[$];
  int  q_o_rdy[$];
  int  q_o_done[$];

  logic       d_pwe, d_prdy, d_pinit;
  logic [6:0] d_paddr;
  logic [7:0] d_pdata;
  logic       o_pwe, o_prdy, o_pinit;
  logic [6:0] o_paddr;
  logic [7:0] o_pdata;

  always @(negedge clk) begin
    if (!d_rstn) begin
      d_pwe <= 1'b0; d_prdy <= 1'b0; d_pinit <= 1'b0;
      d_paddr <= '0; d_pdata <= '0;
    end else begin
      if (d_we) begin
        q_d.push_back('{cyc_d, d_addr, d_wdata});
        chk("d_we_twice", 32'(d_pwe), 32'd0);
        chk("d_setup_addr", 32'(d_addr), 32'(d_paddr));
        chk("d_setup_data", 32'(d_wdata), 32'(d_pdata));
        chk("d_rdy_in_wr", 32'(d_ready), 32'd0);
      end
      if (d_ready && !d_prdy) q_d_rdy.push_back(cyc_d);
      if (d_init && !d_pinit) q_d_init.push_back(cyc_d);
      d_pwe <= d_we; d_prdy <= d_ready; d_pinit <= d_init;
      d_paddr <= d_addr; d_pdata <= d_wdata;
    end
  end

  always @(negedge clk) begin
    if (!o_rstn) begin
      o_pwe <= 1'b0; o_prdy <= 1'b0; o_pinit <= 1'b0;
      o_paddr <= '0; o_pdata <= '0;
    end else begin
      if (o_we) begin
        q_o.push_back('{cyc_o, o_addr, o_wdata});
        chk("o_we_twice", 32'(o_pwe), 32'd0);
        chk("o_setup_addr", 32'(o_addr), 32'(o_paddr));
        chk("o_setup_data", 32'(o_wdata), 32'(o_pdata));
        chk("o_rdy_in_wr", 32'(o_ready), 32'd0);
        chk("o_busy_in_wr", 32'(o_busy), 32'd1);
      end
      if (o_ready && !o_prdy) begin
        q_o_rdy.push_back(cyc_o);
        chk("o_busy_idle", 32'(o_busy), 32'd0);
        chk("o_init_at_rdy", 32'(o_init), 32'd1);
      end
      if (o_init && !o_pinit) q_o_init.push_back(cyc_o);
      if (o_done) begin
        q_o_done.push_back(cyc_o);
        chk("o_rdy_and_done", 32'(o_ready), 32'd0);
      end
      o_pwe <= o_we; o_prdy <= o_ready; o_pinit <= o_init;
      o_paddr <= o_addr; o_pdata <= o_wdata;
    end
  end

  wr_t exp_d [0:7] = '{
    '{26, 7'h05, 8'h00}, '{28, 7'h00, 8'h00},
    '{280, 7'h05, 8'h07}, '{282, 7'h04, 8'h00},
    '{284, 7'h03, 8'h00}, '{286, 7'h02, 8'h13},
    '{288, 7'h01, 8'h00}, '{290, 7'h00, 8'h00}
  };

  wr_t exp_o [0:26] = '{
    '{26, 7'h05, 8'h00}, '{28, 7'h00, 8'h00},
    '{34, 7'h05, 8'h07}, '{36, 7'h04, 8'h00},
    '{38, 7'h03, 8'h00}, '{40, 7'h02, 8'h13},
    '{42, 7'h01, 8'h00}, '{44, 7'h00, 8'h00},
    '{51, 7'h48, 8'h00}, '{53, 7'h05, 8'h11},
    '{55, 7'h04, 8'h5D}, '{57, 7'h03, 8'hA1},
    '{59, 7'h02, 8'hB2}, '{61, 7'h01, 8'hC3},
    '{63, 7'h00, 8'hD4},
    '{76, 7'h48, 8'h00}, '{78, 7'h05, 8'h11},
    '{80, 7'h04, 8'h5D}, '{82, 7'h03, 8'h55},
    '{26, 7'h05, 8'h00}, '{28, 7'h00, 8'h00},
    '{34, 7'h05, 8'h07}, '{36, 7'h04, 8'h00},
    '{38, 7'h03, 8'h00}, '{40, 7'h02, 8'h13},
    '{42, 7'h01, 8'h00}, '{44, 7'h00, 8'h00}
  };

  int exp_o_rdy [0:2] = '{49, 74, 49};
  int exp_o_init [0:1] = '{49, 49};

  task automatic chk_o_reset(input string tag);
    chk({tag, "_addr"}, 32'(o_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(o_wdata), 32'd0);
    chk({tag, "_we"}, 32'(o_we), 32'd0);
    chk({tag, "_ready"}, 32'(o_ready), 32'd0);
    chk({tag, "_done"}, 32'(o_done), 32'd0);
    chk({tag, "_init"}, 32'(o_init), 32'd0);
    chk({tag, "_busy"}, 32'(o_busy), 32'd1);
  endtask

  initial begin
    d_rstn = 1'b1; o_rstn = 1'b1;
    d_valid = 1'b0; d_block = 32'd0;
    o_valid = 1'b1; o_block = 32'hA1B2C3D4;
    #2;
    d_rstn = 1'b0; o_rstn = 1'b0;
    #1;
    chk_o_reset("rst0");
    chk("rst0_d_busy", 32'(d_busy), 32'd1);
    chk("rst0_d_ready", 32'(d_ready), 32'd0);
    chk("rst0_d_we", 32'(d_we), 32'd0);
    repeat (2) @(negedge clk);
    #2;
    d_rstn = 1'b1; o_rstn = 1'b1;

    while (cyc_o < 50) @(negedge clk);
    o_block = 32'h55667788;

    while (cyc_o < 83) @(negedge clk);
    chk("pre_rst_init", 32'(o_init), 32'd1);
    chk("pre_rst_busy", 32'(o_busy), 32'd1);
    chk("pre_rst_addr", 32'(o_addr), 32'd2);
    #2;
    o_rstn = 1'b0;
    #1;
    chk_o_reset("rst_rd");
    o_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    o_rstn = 1'b1;

    while (cyc_d < 800) @(negedge clk);

    chk("o_nwr", 32'(q_o.size()), 32'd27);
    for (int i = 0; i < 27; i++) begin
      if (i < q_o.size()) begin
        chk($sformatf("o_wr%0d_cyc", i), 32'(q_o[i].cyc),
            32'(exp_o[i].cyc));
        chk($sformatf("o_wr%0d_addr", i), 32'(q_o[i].a),
            32'(exp_o[i].a));
        chk($sformatf("o_wr%0d_data", i), 32'(q_o[i].d),
            32'(exp_o[i].d));
      end
    end

    chk("o_nrdy", 32'(q_o_rdy.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      if (i < q_o_rdy.size())
        chk($sformatf("o_rdy%0d_cyc", i), 32'(q_o_rdy[i]),
            32'(exp_o_rdy[i]));
    chk("o_ninit", 32'(q_o_init.size()), 32'd2);
    for (int i = 0; i < 2; i++)
      if (i < q_o_init.size())
        chk($sformatf("o_init%0d_cyc", i), 32'(q_o_init[i]),
            32'(exp_o_init[i]));
    chk("o_ndone", 32'(q_o_done.size()), 32'd1);
    if (q_o_done.size() > 0)
      chk("o_done_cyc", 32'(q_o_done[0]), 32'd73);

    chk("d_nwr", 32'(q_d.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < q_d.size()) begin
        chk($sformatf("d_wr%0d_cyc", i), 32'(q_d[i].cyc),
            32'(exp_d[i].cyc));
        chk($sformatf("d_wr%0d_addr", i), 32'(q_d[i].a),
            32'(exp_d[i].a));
        chk($sformatf("d_wr%0d_data", i), 32'(q_d[i].d),
            32'(exp_d[i].d));
      end
    end
    chk("d_ninit", 32'(q_d_init.size()), 32'd1);
    if (q_d_init.size() > 0)
      chk("d_init_cyc", 32'(q_d_init[0]), 32'd791);
    chk("d_nrdy", 32'(q_d_rdy.size()), 32'd1);
    if (q_d_rdy.size() > 0)
      chk("d_rdy_cyc", 32'(q_d_rdy[0]), 32'd791);
    chk("d_busy_end", 32'(d_busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
